acc_mem_arbiter: RTL



---
 rtl/acc_mem_arb_pkg.sv | 20 ++
 rtl/acc_rr_picker.sv | 31 +++
 rtl/acc_mem_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/acc_mem_arb_pkg.sv
// Shared types and default widths for the accelerator/Data Memory arbiter.
package acc_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    localparam int DEF_ADDR_SIZE    = 16;
    localparam int DEF_RD_DATA_SIZE = 512;
    localparam int DEF_WR_DATA_SIZE = 32;

endpackage

// File: rtl/acc_rr_picker.sv
// Combinational round-robin search: first set request strictly after last_grant_i, wrapping.
module acc_rr_picker #(
    parameter int NUM_ACC = 4
) (
    input  logic [NUM_ACC-1:0]         req_i,
    input  logic [$clog2(NUM_ACC)-1:0] last_grant_i,
    output logic [$clog2(NUM_ACC)-1:0] grant_o,
    output logic                       any_req_o
);

    localparam int IDX_W = $clog2(NUM_ACC);

    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        grant_o = last_grant_i;
        cand    = last_grant_i;
        found   = 1'b0;
        // Offset NUM_ACC lands back on last_grant_i, so a lone requester can win again.
        for (int off = 1; off <= NUM_ACC; off++) begin
            cand = IDX_W'((int'(last_grant_i) + off) % NUM_ACC);
            if (!found && req_i[cand]) begin
                found   = 1'b1;
                grant_o = cand;
            end
        end
        any_req_o = |req_i;
    end

endmodule

// File: rtl/acc_mem_arbiter.sv
// Round-robin arbiter sharing one single-port Data Memory among NUM_ACC accelerators.
// Optional per-requester completion counters: define ACC_MEM_ARB_PERF_CNT_EN.
module acc_mem_arbiter
    import acc_mem_arb_pkg::*;
#(
    parameter int NUM_ACC      = 4,
    parameter int ADDR_SIZE    = DEF_ADDR_SIZE,
    parameter int RD_DATA_SIZE = DEF_RD_DATA_SIZE,
    parameter int WR_DATA_SIZE = DEF_WR_DATA_SIZE,
    parameter int RD_LATENCY   = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_ACC-1:0]              acc_read_en,
    input  logic [NUM_ACC*ADDR_SIZE-1:0]    acc_read_addr,
    output logic [RD_DATA_SIZE-1:0]         acc_read_data,
    output logic [NUM_ACC-1:0]              acc_read_data_valid,
    input  logic [NUM_ACC-1:0]              acc_write_en,
    input  logic [NUM_ACC*ADDR_SIZE-1:0]    acc_write_addr,
    input  logic [NUM_ACC*WR_DATA_SIZE-1:0] acc_write_data,
    output logic [NUM_ACC-1:0]              acc_write_done,
    output logic                            mem_en,
    output logic                            mem_we,
    output logic [ADDR_SIZE-1:0]            mem_addr,
    output logic [WR_DATA_SIZE-1:0]         mem_wdata,
    input  logic [RD_DATA_SIZE-1:0]         mem_rdata
`ifdef ACC_MEM_ARB_PERF_CNT_EN
    ,
    output logic [NUM_ACC*32-1:0]           perf_grant_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_ACC);
    localparam int CNT_W = 3;

    arb_state_t              state_q, state_d;
    logic [IDX_W-1:0]        grant_q, grant_d;
    op_t                     op_q, op_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [RD_DATA_SIZE-1:0] rdata_q, rdata_d;

    logic [NUM_ACC-1:0]      req;
    logic [IDX_W-1:0]        pick;
    logic                    any_req;

    assign req = acc_read_en | acc_write_en;

    acc_rr_picker #(
        .NUM_ACC(NUM_ACC)
    ) u_picker (
        .req_i       (req),
        .last_grant_i(grant_q),
        .grant_o     (pick),
        .any_req_o   (any_req)
    );

    // grant_q doubles as the round-robin pointer; it is only rewritten in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= IDX_W'(NUM_ACC - 1);
            op_q    <= OP_READ;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        grant_d             = grant_q;
        op_d                = op_q;
        cnt_d               = cnt_q;
        rdata_d             = rdata_q;
        mem_en              = 1'b0;
        mem_we              = 1'b0;
        mem_addr            = '0;
        mem_wdata           = '0;
        acc_read_data_valid = '0;
        acc_write_done      = '0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick;
                    op_d    = acc_write_en[pick] ? OP_WRITE : OP_READ;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = (op_q == OP_WRITE);
                mem_addr  = (op_q == OP_WRITE) ? acc_write_addr[grant_q*ADDR_SIZE +: ADDR_SIZE]
                                               : acc_read_addr[grant_q*ADDR_SIZE +: ADDR_SIZE];
                mem_wdata = acc_write_data[grant_q*WR_DATA_SIZE +: WR_DATA_SIZE];
                if (op_q == OP_WRITE) begin
                    state_d = RESP;
                end else begin
                    cnt_d   = CNT_W'(RD_LATENCY);
                    state_d = WAIT_RD;
                end
            end
            WAIT_RD: begin
                // Count 1 marks the cycle in which mem_rdata carries the requested block.
                if (cnt_q == CNT_W'(1)) begin
                    rdata_d = mem_rdata;
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                acc_read_data_valid[grant_q] = (op_q == OP_READ);
                acc_write_done[grant_q]      = (op_q == OP_WRITE);
                state_d                      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign acc_read_data = rdata_q;

`ifdef ACC_MEM_ARB_PERF_CNT_EN
    logic [NUM_ACC*32-1:0] perf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else if (state_q == RESP) begin
            perf_q[grant_q*32 +: 32] <= perf_q[grant_q*32 +: 32] + 32'd1;
        end
    end

    assign perf_grant_cnt = perf_q;
`endif

endmodule
